// File: rtl/sigmoid_lut_loader.sv
// rtl/sigmoid_lut_loader.sv - sigmoid segment table loader with combinational base/next reads
// Optional checksum stage enabled by defining SIGMOID_LUT_CHECKSUM_EN.
module sigmoid_lut_loader #(
    parameter int ENTRIES = 17,
    parameter int WIDTH   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_wr_valid,
    input  logic signed [WIDTH-1:0] i_wr_data,
    output logic                    o_wr_ready,
    input  logic [3:0]              i_address,
    output logic signed [WIDTH-1:0] o_base,
    output logic signed [WIDTH-1:0] o_next_data,
    output logic                    o_loaded,
    output logic                    o_busy,
    output logic                    o_error
);

    localparam int CW = $clog2(ENTRIES);
    localparam logic [CW-1:0] LAST_IDX = CW'(ENTRIES - 1);

`ifdef SIGMOID_LUT_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD} state_t;
`endif

    state_t                  r_state;
    logic [CW-1:0]           r_count;
    logic signed [WIDTH-1:0] r_table [ENTRIES];
    logic                    r_loaded;
    logic                    r_busy;
    logic                    r_wr_ready;
`ifdef SIGMOID_LUT_CHECKSUM_EN
    logic [WIDTH-1:0]        r_sum;
    logic                    r_error;
`endif

    logic                    w_hs;
    logic [CW-1:0]           w_idx_base;
    logic [CW-1:0]           w_idx_next;

    assign w_hs       = i_wr_valid & r_wr_ready;
    // Index is one bit wider than the address so address 15 reaches the end-point entry.
    assign w_idx_base = CW'(i_address);
    assign w_idx_next = CW'(i_address) + CW'(1);

    assign o_base      = r_table[w_idx_base];
    assign o_next_data = r_table[w_idx_next];
    assign o_wr_ready  = r_wr_ready;
    assign o_busy      = r_busy;
    assign o_loaded    = r_loaded;
`ifdef SIGMOID_LUT_CHECKSUM_EN
    assign o_error     = r_error;
`else
    assign o_error     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_loaded   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
`ifdef SIGMOID_LUT_CHECKSUM_EN
            r_sum      <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_LOAD;
                        r_count    <= '0;
                        r_loaded   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b1;
`ifdef SIGMOID_LUT_CHECKSUM_EN
                        r_sum      <= '0;
                        r_error    <= 1'b0;
`endif
                    end
                end

                S_LOAD: begin
                    // Abort wins over a same-cycle handshake; written entries are kept.
                    if (i_abort) begin
                        r_state    <= S_IDLE;
                        r_loaded   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b0;
                    end else if (w_hs) begin
                        r_table[r_count] <= i_wr_data;
                        r_count          <= r_count + CW'(1);
`ifdef SIGMOID_LUT_CHECKSUM_EN
                        r_sum            <= r_sum + $unsigned(i_wr_data);
                        if (r_count == LAST_IDX) begin
                            r_state <= S_CHECK;
                        end
`else
                        if (r_count == LAST_IDX) begin
                            r_state    <= S_IDLE;
                            r_loaded   <= 1'b1;
                            r_busy     <= 1'b0;
                            r_wr_ready <= 1'b0;
                        end
`endif
                    end
                end

`ifdef SIGMOID_LUT_CHECKSUM_EN
                S_CHECK: begin
                    if (i_abort) begin
                        r_state    <= S_IDLE;
                        r_loaded   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b0;
                    end else if (w_hs) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b0;
                        if ($unsigned(i_wr_data) == r_sum) begin
                            r_loaded <= 1'b1;
                            r_error  <= 1'b0;
                        end else begin
                            r_loaded <= 1'b0;
                            r_error  <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// tb/tb_sigmoid_lut_loader.sv - scoreboard bench for sigmoid_lut_loader
module tb_sigmoid_lut_loader;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              wr_valid;
    logic signed [7:0] wr_data;
    logic              wr_ready;
    logic [3:0]        address;
    logic signed [7:0] base;
    logic signed [7:0] next_data;
    logic              loaded;
    logic              busy;
    logic              error;

    always #5 clk = ~clk;

    sigmoid_lut_loader #(.ENTRIES(17), .WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_wr_valid  (wr_valid),
        .i_wr_data   (wr_data),
        .o_wr_ready  (wr_ready),
        .i_address   (address),
        .o_base      (base),
        .o_next_data (next_data),
        .o_loaded    (loaded),
        .o_busy      (busy),
        .o_error     (error)
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp_base;
        logic [7:0] exp_next;
    } rd_t;

    rd_t        sb_q[$];
    logic [7:0] model[17];
    int         model_cnt;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reads();
        for (int a = 0; a < 16; a++) begin
            sb_q.push_back('{addr: 4'(a), exp_base: model[a], exp_next: model[a+1]});
        end
    endtask

    task automatic drain_reads(input string tag);
        rd_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            address = e.addr;
            #1;
            check_eq($sformatf("%s_base[%0d]", tag, e.addr), 32'(base), 32'(e.exp_base));
            check_eq($sformatf("%s_next[%0d]", tag, e.addr), 32'(next_data), 32'(e.exp_next));
        end
    endtask

    task automatic start_load();
        start = 1'b1;
        step();
        start = 1'b0;
        model_cnt = 0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_ready", 32'(wr_ready), 32'd1);
        check_eq("start_loaded", 32'(loaded), 32'd0);
    endtask

    task automatic send(input logic [7:0] data, input bit to_table);
        bit hs;
        wr_valid = 1'b1;
        wr_data  = data;
        hs = wr_ready && !abort;
        step();
        wr_valid = 1'b0;
        if (hs && to_table && model_cnt < 17) begin
            model[model_cnt] = data;
            model_cnt++;
        end
    endtask

    task automatic load_words(input logic [7:0] first, input bit gaps, input string tag);
        logic [7:0] sum;
        sum = 8'h00;
        start_load();
        for (int i = 0; i < 17; i++) begin
            if (i == 16) check_eq({tag, "_loaded_before_last"}, 32'(loaded), 32'd0);
            send(8'(first + 8'(i)), 1'b1);
            sum = 8'(sum + first + 8'(i));
            if (gaps && i < 16) begin
                if (i == 8) start = 1'b1;
                step();
                start = 1'b0;
                check_eq({tag, "_ready_in_gap"}, 32'(wr_ready), 32'd1);
            end
        end
`ifdef SIGMOID_LUT_CHECKSUM_EN
        check_eq({tag, "_busy_in_check"}, 32'(busy), 32'd1);
        send(sum, 1'b0);
`endif
        check_eq({tag, "_loaded_after_last"}, 32'(loaded), 32'd1);
        check_eq({tag, "_busy_after_last"}, 32'(busy), 32'd0);
        check_eq({tag, "_ready_after_last"}, 32'(wr_ready), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'sh00;
        address  = 4'd0;
        for (int i = 0; i < 17; i++) model[i] = 8'h00;
        model_cnt = 0;

        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_loaded", 32'(loaded), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        push_reads();
        drain_reads("rst");
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Back-to-back load of 0x08..0x18
        load_words(8'h08, 1'b0, "b2b");
        address = 4'd4;
        #1;
        check_eq("b2b_addr4_base", 32'(base), 32'h0C);
        check_eq("b2b_addr4_next", 32'(next_data), 32'h0D);
        address = 4'd15;
        #1;
        check_eq("b2b_addr15_next", 32'(next_data), 32'h18);
        push_reads();
        drain_reads("b2b");

        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("idle_abort_loaded", 32'(loaded), 32'd1);
        check_eq("idle_abort_busy", 32'(busy), 32'd0);

        // Stalled load with a start pulse inside a gap
        step();
        load_words(8'h20, 1'b1, "gap");
        push_reads();
        drain_reads("gap");

        // Abort after five words, with a same-cycle handshake that must be dropped
        step();
        start_load();
        for (int i = 0; i < 5; i++) send(8'(8'h40 + 8'(i)), 1'b1);
        abort = 1'b1;
        send(8'h77, 1'b1);
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_loaded", 32'(loaded), 32'd0);
        check_eq("abort_ready", 32'(wr_ready), 32'd0);
        push_reads();
        drain_reads("abort");

        // Reset in the middle of a load
        step();
        start_load();
        for (int i = 0; i < 10; i++) send(8'(8'h60 + 8'(i)), 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_loaded", 32'(loaded), 32'd0);
        check_eq("midrst_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 17; i++) model[i] = 8'h00;
        push_reads();
        drain_reads("midrst");
        rst_n = 1'b1;
        step();
        wr_valid = 1'b1;
        wr_data  = 8'sh55;
        step();
        wr_valid = 1'b0;
        check_eq("postrst_busy", 32'(busy), 32'd0);
        check_eq("postrst_ready", 32'(wr_ready), 32'd0);
        push_reads();
        drain_reads("postrst");

`ifdef SIGMOID_LUT_CHECKSUM_EN
        step();
        start_load();
        for (int i = 0; i < 17; i++) send(8'h10, 1'b1);
        send(8'h10, 1'b0);
        check_eq("cs_ok_loaded", 32'(loaded), 32'd1);
        check_eq("cs_ok_error", 32'(error), 32'd0);
        step();
        start_load();
        for (int i = 0; i < 17; i++) send(8'h10, 1'b1);
        send(8'h11, 1'b0);
        check_eq("cs_bad_loaded", 32'(loaded), 32'd0);
        check_eq("cs_bad_error", 32'(error), 32'd1);
        check_eq("cs_bad_busy", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/sigmoid_lut_loader.md
SIGMOID_LUT_LOADER -- requirements
Module: sigmoid_lut_loader

Interface
- REQ-001: Parameter ENTRIES, default 17, is the number of table words: 16 segment bases plus one end-point.
- REQ-002: Parameter WIDTH, default 8, is the signed fixed-point word width, with a 4-bit fraction (1.0 = 8'h10).
- REQ-003: clk, input, 1: single clock; all state changes on its rising edge.
- REQ-004: rst, input, 1: asynchronous, active-low reset.
- REQ-005: start, input, 1: begins a table load when sampled high in IDLE.
- REQ-006: abort, input, 1: cancels a load in progress.
- REQ-007: wr_valid, input, 1: the producer has a table word on wr_data.
- REQ-008: wr_data, input, WIDTH (signed): table word, or checksum byte when configured.
- REQ-009: wr_ready, output, 1: the loader accepts wr_data this cycle.
- REQ-010: address, input, 4: segment select from the activation block, equal to z_value[7:4].
- REQ-011: base, output, WIDTH (signed): table[address], combinational.
- REQ-012: next_data, output, WIDTH (signed): table[address+1], combinational.
- REQ-013: loaded, output, 1: the table is complete and valid.
- REQ-014: busy, output, 1: the FSM is not in IDLE.
- REQ-015: error, output, 1: a checksum mismatch occurred on the last load.

Function
- REQ-016: The FSM states are IDLE, LOAD and CHECK; CHECK exists only with SIGMOID_LUT_CHECKSUM_EN.
- REQ-017: In IDLE, wr_ready is 0. start=1 clears loaded, error, the word counter and the checksum, and moves the FSM to LOAD on the next edge.
- REQ-018: start is ignored outside IDLE.
- REQ-019: In LOAD, wr_ready is 1. On each wr_valid&wr_ready, table[counter] <= wr_data and counter increments.
- REQ-020: The written word is visible on base and next_data from the following cycle.
- REQ-021: When the handshake with counter==16 completes, the FSM goes to CHECK if the macro is defined; otherwise it goes to IDLE and sets loaded=1 on the same edge.
- REQ-022: A wr_valid=0 cycle in LOAD inserts a stall. The counter holds, with no timeout.
- REQ-023: abort=1 in LOAD or CHECK returns the FSM to IDLE on the next edge with loaded=0. Entries already written are retained, and a handshake in the same cycle is discarded.
- REQ-024: abort has priority over a simultaneous handshake. abort in IDLE has no effect.
- REQ-025: Reads are never blocked. During a load, base and next_data show the partially updated table, and consumers gate on loaded.
- REQ-026: address 15 reads table[15] and table[16]. The index never wraps to 0.
- REQ-027: busy = (state != IDLE).
- REQ-028: wr_ready depends only on state, never on wr_valid.

Reset
- REQ-029: While rst=0, the FSM is in IDLE, counter=0, every table entry=0, loaded=0, error=0, busy=0 and wr_ready=0.
- REQ-030: Reset asserted mid-load takes effect immediately and asynchronously. After release, a fresh start is required.
- REQ-031: base and next_data read 0 after reset for every address.

Configuration
- REQ-032: With SIGMOID_LUT_CHECKSUM_EN defined, a running modulo-256 sum of the 17 accepted words is kept.
- REQ-033: In CHECK, wr_ready=1 and one byte is accepted.
- REQ-034: On a checksum match, the loader sets loaded=1 and error=0.
- REQ-035: On a checksum mismatch, the loader sets loaded=0 and error=1.
- REQ-036: After the checksum byte is accepted, the FSM returns to IDLE in either case.
- REQ-037: Without the macro, the CHECK state and the sum register are absent, error is constant 0, and the load ends after the 17th word.

Verification
- REQ-038: Load words 0x08,0x09,...,0x18 back-to-back, then set address=4 -> base=0x0C, next_data=0x0D, and loaded rises exactly one edge after the 17th handshake (macro off).
- REQ-039: Load with wr_valid toggling 1,0,1,0 -> 17 words are stored in order, the counter holds during gaps, and loaded=1 only after the 17th word.
- REQ-040: Assert abort after 5 words -> the next edge gives IDLE with loaded=0, and table[0..4] are written while table[5..16] are unchanged.
- REQ-041: Assert rst=0 after 10 words -> busy, loaded and wr_ready are 0 immediately, and all reads return 0.
- REQ-042: With the macro on, 17 words of 0x10 followed by checksum 0x10 -> loaded=1, error=0; a second load with checksum 0x11 -> loaded=0, error=1.
- REQ-043: Set address=15 after a full load -> next_data=table[16]; pulsing start during LOAD does not change the counter.
